// File: rtl/config_pkg.sv
// Core configuration shared by the issue-side blocks.
//   cfg_t     : configuration record (RS_DEPTH = reservation station entries)
//   EmptyCfg  : default configuration used when no core config is supplied
//   RS_IDX_W  : entry index width for the default configuration
//   rs_depth_ok() : legality check for RS_DEPTH, used by an elaboration-time check
package config_pkg;

    typedef struct packed {
        int unsigned RS_DEPTH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{RS_DEPTH: 32'd8};

    localparam int unsigned RS_IDX_W = $clog2(EmptyCfg.RS_DEPTH);

    // The scheduler needs at least four entries.
    function automatic bit rs_depth_ok(input int unsigned depth);
        return depth >= 32'd4;
    endfunction

endpackage

// File: rtl/rs_issue_ctrl_age_pick.sv
// rs_age_pick: selects the oldest requesting entry from an age matrix.
//   req   : candidate entry mask
//   older : older[i][j] = 1 means entry i is older than entry j
//   valid : at least one candidate requested
//   idx   : index of the oldest candidate (lowest index on a tie, 0 if none)
module rs_age_pick #(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned RS_IDX_W = 3
) (
    input  logic [RS_DEPTH-1:0]               req,
    input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older,
    output logic                              valid,
    output logic [RS_IDX_W-1:0]               idx
);

    logic [RS_DEPTH-1:0] is_oldest;

    // An entry is oldest if no other candidate is older than it.
    always_comb begin
        is_oldest = req;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            for (int j = 0; j < int'(RS_DEPTH); j++) begin
                if (i != j && req[j] && older[j][i]) begin
                    is_oldest[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        valid = |req;
        idx   = '0;
        // Descending scan so the lowest set index wins.
        for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
            if (is_oldest[i]) begin
                idx = RS_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_issue_ctrl.sv
// rs_issue_ctrl: allocation and oldest-first dual issue for one reservation station.
//   busy_vector / ready_mask    : RS occupancy and operand-ready state
//   disp_valid / disp_ready     : dispatch lanes in, all-or-nothing acceptance out
//   disp_idx / entry_wen        : entry assigned per lane, one-hot write enables to RS
//   alu_ready_0/1               : ALU back-pressure
//   issue_valid_0/1, sel_idx_0/1: per-port issue and selected entry
//   issue_grant                 : OR of the one-hot issue selections, to RS
// All outputs are combinational and forced to zero while rst_n is low.
module rs_issue_ctrl
    import config_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg      = config_pkg::EmptyCfg,
    parameter int unsigned      RS_DEPTH = Cfg.RS_DEPTH,
    parameter int unsigned      RS_IDX_W = $clog2(Cfg.RS_DEPTH),
    parameter int unsigned      DISP_W   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [RS_DEPTH-1:0]              busy_vector,
    input  logic [RS_DEPTH-1:0]              ready_mask,
    input  logic [DISP_W-1:0]                disp_valid,
    output logic                             disp_ready,
    output logic [DISP_W-1:0][RS_IDX_W-1:0]  disp_idx,
    output logic [RS_DEPTH-1:0]              entry_wen,
    input  logic                             alu_ready_0,
    input  logic                             alu_ready_1,
    output logic                             issue_valid_0,
    output logic                             issue_valid_1,
    output logic [RS_IDX_W-1:0]              sel_idx_0,
    output logic [RS_IDX_W-1:0]              sel_idx_1,
    output logic [RS_DEPTH-1:0]              issue_grant
);

    if (!rs_depth_ok(RS_DEPTH)) begin : g_bad_depth
        $error("rs_issue_ctrl: RS_DEPTH must be at least 4");
    end

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

    logic [RS_DEPTH-1:0]             free;
    logic [RS_DEPTH-1:0]             free_rem;
    logic [DISP_W-1:0][RS_IDX_W-1:0] alloc_idx;
    logic [DISP_W-1:0]               lane_acc;
    logic                            disp_ready_raw;
    logic [RS_DEPTH-1:0]             wen_raw;

    logic [RS_DEPTH-1:0] cand, cand1;
    logic                pick0_valid, pick1_valid;
    logic [RS_IDX_W-1:0] pick0_idx, pick1_idx;
    logic                valid0_raw, valid1_raw;
    logic [RS_DEPTH-1:0] grant_raw;

    // Allocation: lane k takes the k-th lowest free entry.
    always_comb begin
        free      = ~busy_vector;
        free_rem  = free;
        alloc_idx = '0;
        for (int k = 0; k < int'(DISP_W); k++) begin
            for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
                if (free_rem[i]) begin
                    alloc_idx[k] = RS_IDX_W'(i);
                end
            end
            // Harmless when nothing is free: bit 0 is already clear then.
            free_rem[alloc_idx[k]] = 1'b0;
        end
        disp_ready_raw = ($countones(free) >= int'(DISP_W));
        lane_acc = '0;
        wen_raw  = '0;
        for (int k = 0; k < int'(DISP_W); k++) begin
            lane_acc[k] = disp_valid[k] & disp_ready_raw;
            if (lane_acc[k]) begin
                wen_raw[alloc_idx[k]] = 1'b1;
            end
        end
    end

    // Age update: a newly written entry becomes younger than every occupied
    // entry; among same-cycle writes, lower lanes are older.
    always_comb begin
        older_d = older_q;
        for (int k = 0; k < int'(DISP_W); k++) begin
            if (lane_acc[k]) begin
                for (int j = 0; j < int'(RS_DEPTH); j++) begin
                    if (busy_vector[j] && (RS_IDX_W'(j) != alloc_idx[k])) begin
                        older_d[j][alloc_idx[k]] = 1'b1;
                        older_d[alloc_idx[k]][j] = 1'b0;
                    end
                end
            end
        end
        for (int k = 0; k < int'(DISP_W); k++) begin
            for (int l = k + 1; l < int'(DISP_W); l++) begin
                if (lane_acc[k] && lane_acc[l]) begin
                    older_d[alloc_idx[k]][alloc_idx[l]] = 1'b1;
                    older_d[alloc_idx[l]][alloc_idx[k]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    assign cand = ready_mask & busy_vector;

    rs_age_pick #(
        .RS_DEPTH (RS_DEPTH),
        .RS_IDX_W (RS_IDX_W)
    ) u_pick0 (
        .req   (cand),
        .older (older_q),
        .valid (pick0_valid),
        .idx   (pick0_idx)
    );

    assign valid0_raw = alu_ready_0 & pick0_valid;
    // Port 1 only excludes port 0's pick when port 0 actually issues, so a
    // stalled ALU 0 hands the oldest candidate to ALU 1.
    assign cand1 = valid0_raw ? (cand & ~(RS_DEPTH'(1) << pick0_idx)) : cand;

    rs_age_pick #(
        .RS_DEPTH (RS_DEPTH),
        .RS_IDX_W (RS_IDX_W)
    ) u_pick1 (
        .req   (cand1),
        .older (older_q),
        .valid (pick1_valid),
        .idx   (pick1_idx)
    );

    assign valid1_raw = alu_ready_1 & pick1_valid;

    always_comb begin
        grant_raw = '0;
        if (valid0_raw) begin
            grant_raw = grant_raw | (RS_DEPTH'(1) << pick0_idx);
        end
        if (valid1_raw) begin
            grant_raw = grant_raw | (RS_DEPTH'(1) << pick1_idx);
        end
    end

    // Outputs are held at zero during reset so the RS sees no writes or grants.
    assign disp_ready    = rst_n & disp_ready_raw;
    assign disp_idx      = rst_n ? alloc_idx : '0;
    assign entry_wen     = rst_n ? wen_raw : '0;
    assign issue_valid_0 = rst_n & valid0_raw;
    assign issue_valid_1 = rst_n & valid1_raw;
    assign sel_idx_0     = (rst_n && valid0_raw) ? pick0_idx : '0;
    assign sel_idx_1     = (rst_n && valid1_raw) ? pick1_idx : '0;
    assign issue_grant   = rst_n ? grant_raw : '0;

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Directed bench for rs_issue_ctrl (RS_DEPTH = 8, DISP_W = 2). The bench plays
// the role of the reservation station by driving busy_vector/ready_mask itself.
module tb_rs_issue_ctrl;

    localparam int unsigned D  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned DW = 2;

    logic               clk;
    logic               rst_n;
    logic [D-1:0]       busy_vector;
    logic [D-1:0]       ready_mask;
    logic [DW-1:0]      disp_valid;
    logic               disp_ready;
    logic [DW-1:0][IW-1:0] disp_idx;
    logic [D-1:0]       entry_wen;
    logic               alu_ready_0;
    logic               alu_ready_1;
    logic               issue_valid_0;
    logic               issue_valid_1;
    logic [IW-1:0]      sel_idx_0;
    logic [IW-1:0]      sel_idx_1;
    logic [D-1:0]       issue_grant;

    int total = 0;
    int bad   = 0;

    rs_issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .busy_vector   (busy_vector),
        .ready_mask    (ready_mask),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_idx      (disp_idx),
        .entry_wen     (entry_wen),
        .alu_ready_0   (alu_ready_0),
        .alu_ready_1   (alu_ready_1),
        .issue_valid_0 (issue_valid_0),
        .issue_valid_1 (issue_valid_1),
        .sel_idx_0     (sel_idx_0),
        .sel_idx_1     (sel_idx_1),
        .issue_grant   (issue_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue-side outputs as one word: {v0, v1, sel0, sel1, grant}
    function automatic logic [63:0] iss();
        return {50'd0, issue_valid_0, issue_valid_1, sel_idx_0, sel_idx_1, issue_grant};
    endfunction

    function automatic logic [63:0] iss_exp(input logic v0, input logic v1,
                                            input logic [2:0] s0, input logic [2:0] s1,
                                            input logic [7:0] g);
        return {50'd0, v0, v1, s0, s1, g};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        busy_vector = '0;
        ready_mask  = '0;
        disp_valid  = 2'b11;
        alu_ready_0 = 1'b1;
        alu_ready_1 = 1'b1;

        // Reset state
        @(negedge clk); #1;
        chk("rst_disp_ready", 64'(disp_ready), 64'd0);
        chk("rst_wen",        64'(entry_wen),  64'd0);
        chk("rst_disp_idx",   64'(disp_idx),   64'd0);
        chk("rst_older",      64'(dut.older_q), 64'd0);

        // First dispatch after reset: entries 0 and 1
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("d0_ready", 64'(disp_ready), 64'd1);
        chk("d0_idx",   64'(disp_idx),   64'h08);   // lane1=1, lane0=0
        chk("d0_wen",   64'(entry_wen),  64'h03);
        @(posedge clk); #1;
        busy_vector = 8'h03;
        chk("d0_older01", 64'(dut.older_q[0][1]), 64'd1);
        chk("d0_older10", 64'(dut.older_q[1][0]), 64'd0);

        // Fill entries 2 and 3
        @(negedge clk); #1;
        chk("d1_idx", 64'(disp_idx),  64'h1a);      // lane1=3, lane0=2
        chk("d1_wen", 64'(entry_wen), 64'h0c);
        @(posedge clk); #1;
        busy_vector = 8'h0f;

        // Free entry 1, dispatch one op into it
        @(negedge clk);
        busy_vector = 8'h0d;
        disp_valid  = 2'b01;
        #1;
        chk("d2_idx0", 64'(disp_idx[0]), 64'd1);
        chk("d2_wen",  64'(entry_wen),   64'h02);
        @(posedge clk); #1;
        busy_vector = 8'h0f;

        // Entry 3 is now older than the re-written entry 1
        @(negedge clk);
        disp_valid = 2'b00;
        ready_mask = 8'h0a;
        #1;
        chk("age_pick", iss(), iss_exp(1'b1, 1'b1, 3'd3, 3'd1, 8'h0a));
        chk("age_wen",  64'(entry_wen), 64'd0);

        // Dispatch into 4 and 5
        @(negedge clk);
        ready_mask = 8'h00;
        disp_valid = 2'b11;
        #1;
        chk("d3_wen", 64'(entry_wen), 64'h30);
        @(posedge clk); #1;
        busy_vector = 8'h3f;

        // ALU 0 back-pressure: oldest of {2,5} moves to port 1
        @(negedge clk);
        disp_valid  = 2'b00;
        ready_mask  = 8'h24;
        alu_ready_0 = 1'b0;
        #1;
        chk("bp_alu0", iss(), iss_exp(1'b0, 1'b1, 3'd0, 3'd2, 8'h04));
        alu_ready_0 = 1'b1;
        alu_ready_1 = 1'b0;
        #1;
        chk("bp_alu1", iss(), iss_exp(1'b1, 1'b0, 3'd2, 3'd0, 8'h04));
        alu_ready_1 = 1'b1;
        #1;
        chk("both_24", iss(), iss_exp(1'b1, 1'b1, 3'd2, 3'd5, 8'h24));

        // Fill 6 and 7
        @(negedge clk);
        ready_mask = 8'h00;
        disp_valid = 2'b11;
        #1;
        chk("d4_wen", 64'(entry_wen), 64'hc0);
        @(posedge clk); #1;
        busy_vector = 8'hff;

        // Full RS with one entry issuing; single ready entry uses port 0 only
        @(negedge clk);
        ready_mask = 8'h01;
        #1;
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_wen",   64'(entry_wen),  64'd0);
        chk("single_iss", iss(), iss_exp(1'b1, 1'b0, 3'd0, 3'd0, 8'h01));
        @(posedge clk); #1;
        busy_vector = 8'hfe;
        ready_mask  = 8'h00;

        // One free entry is not enough, even with only lane 0 valid
        @(negedge clk);
        disp_valid = 2'b01;
        #1;
        chk("one_free_ready", 64'(disp_ready), 64'd0);
        chk("one_free_wen",   64'(entry_wen),  64'd0);

        // Two free entries (0 and 2)
        @(negedge clk);
        busy_vector = 8'hfa;
        disp_valid  = 2'b11;
        #1;
        chk("two_free_ready", 64'(disp_ready), 64'd1);
        chk("two_free_idx",   64'(disp_idx),   64'h10);  // lane1=2, lane0=0
        chk("two_free_wen",   64'(entry_wen),  64'h05);
        @(posedge clk); #1;
        busy_vector = 8'hff;
        chk("age_02", 64'(dut.older_q[0][2]), 64'd1);
        chk("age_20", 64'(dut.older_q[2][0]), 64'd0);
        chk("age_70", 64'(dut.older_q[7][0]), 64'd1);

        // Reset mid-traffic
        @(negedge clk);
        busy_vector = 8'h0f;
        ready_mask  = 8'h0f;
        disp_valid  = 2'b11;
        #1;
        chk("pre_rst_ready", 64'(disp_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_disp",  {31'd0, disp_ready, 16'(disp_idx), 16'(entry_wen)}, 64'd0);
        chk("mid_rst_iss",   iss(), 64'd0);
        chk("mid_rst_older", 64'(dut.older_q), 64'd0);
        busy_vector = 8'h00;
        ready_mask  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idx", 64'(disp_idx),  64'h08);
        chk("post_rst_wen", 64'(entry_wen), 64'h03);
        @(posedge clk); #1;
        chk("post_rst_older01", 64'(dut.older_q[0][1]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
